// File: rtl/watch_timekeeper.sv
// watch_timekeeper: time-of-day (hh:mm:ss) and stopwatch (mm:ss) counting core.
// Executes the run/adjust/stopwatch strobes from the watch state controller and
// publishes binary digit values. Each counter has its own prescaler to 1 Hz.
// Optional build macro TWELVE_HOUR_EN: 12-hour display (1-12) with a PM flag;
// when undefined the clock runs 0-23 and pm is tied low.
module watch_timekeeper #(
  parameter int TICKS_PER_SEC    = 32768,
  parameter int SW_TICKS_PER_SEC = 32768
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_time,
  input  logic       inc_m,
  input  logic       dec_m,
  input  logic       inc_h,
  input  logic       dec_h,
  input  logic       run_stopwatch,
  input  logic       reset_stopwatch,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [5:0] sw_minutes,
  output logic [5:0] sw_seconds,
  output logic       sec_tick,
  output logic       pm
);

  localparam int TW  = $clog2(TICKS_PER_SEC);
  localparam int SWW = $clog2(SW_TICKS_PER_SEC);
  localparam logic [TW-1:0]  T_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [SWW-1:0] SW_LAST = SWW'(SW_TICKS_PER_SEC - 1);

`ifdef TWELVE_HOUR_EN
  localparam logic [4:0] H_FIRST = 5'd1;
  localparam logic [4:0] H_LAST  = 5'd12;
  localparam logic [4:0] H_RESET = 5'd12;
`else
  localparam logic [4:0] H_FIRST = 5'd0;
  localparam logic [4:0] H_LAST  = 5'd23;
  localparam logic [4:0] H_RESET = 5'd0;
`endif

  function automatic logic [5:0] wrap_up60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dn60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] hour_up(input logic [4:0] h);
    return (h == H_LAST) ? H_FIRST : h + 5'd1;
  endfunction

  function automatic logic [4:0] hour_dn(input logic [4:0] h);
    return (h == H_FIRST) ? H_LAST : h - 5'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Adjust request edge detection
  // ---------------------------------------------------------------------------
  logic [3:0] req;
  logic [3:0] req_q;
  logic [3:0] req_rise;
  logic       inc_m_rise;
  logic       dec_m_rise;
  logic       inc_h_rise;
  logic       dec_h_rise;

  assign req      = {inc_m, dec_m, inc_h, dec_h};
  assign req_rise = req & ~req_q;
  assign {inc_m_rise, dec_m_rise, inc_h_rise, dec_h_rise} = req_rise;

  // History of the adjust levels, updated every cycle regardless of mode.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) req_q <= '0;
    else       req_q <= req;
  end

  // ---------------------------------------------------------------------------
  // Time of day
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tpre;
  logic [TW-1:0] tpre_next;
  logic [5:0]    sec_next;
  logic [5:0]    min_next;
  logic [4:0]    hour_next;
  logic          tick_next;
`ifdef TWELVE_HOUR_EN
  logic          pm_flip;
`endif

  // Next time-of-day: set-mode adjusts, or prescaler advance with full carry chain.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tpre_next = tpre;
    sec_next  = seconds;
    min_next  = minutes;
    hour_next = hours;
    tick_next = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_flip   = 1'b0;
`endif
    if (!run_time) begin
      // Set mode: prescaler and seconds parked at 0 so a restart gives a full second.
      tpre_next = '0;
      sec_next  = '0;
      if (inc_m_rise != dec_m_rise)
        min_next = inc_m_rise ? wrap_up60(minutes) : wrap_dn60(minutes);
      if (inc_h_rise && !dec_h_rise) begin
        hour_next = hour_up(hours);
`ifdef TWELVE_HOUR_EN
        pm_flip   = (hours == 5'd11);
`endif
      end else if (dec_h_rise && !inc_h_rise) begin
        hour_next = hour_dn(hours);
`ifdef TWELVE_HOUR_EN
        pm_flip   = (hours == 5'd12);
`endif
      end
    end else if (tpre == T_LAST) begin
      tpre_next = '0;
      tick_next = 1'b1;
      sec_next  = wrap_up60(seconds);
      if (seconds == 6'd59) begin
        min_next = wrap_up60(minutes);
        if (minutes == 6'd59) begin
          hour_next = hour_up(hours);
`ifdef TWELVE_HOUR_EN
          pm_flip   = (hours == 5'd11);
`endif
        end
      end
    end else begin
      tpre_next = tpre + TW'(1);
    end
  end

  // Time-of-day registers and the one-cycle second pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      tpre     <= '0;
      seconds  <= '0;
      minutes  <= '0;
      hours    <= H_RESET;
      sec_tick <= 1'b0;
    end else begin
      tpre     <= tpre_next;
      seconds  <= sec_next;
      minutes  <= min_next;
      hours    <= hour_next;
      sec_tick <= tick_next;
    end
  end

`ifdef TWELVE_HOUR_EN
  // PM flag toggles when the hour passes between 11 and 12 in either direction.
  always_ff @(posedge clk) begin
    if (reset)        pm <= 1'b0;
    else if (pm_flip) pm <= ~pm;
  end
`else
  assign pm = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stopwatch
  // ---------------------------------------------------------------------------
  logic [SWW-1:0] swpre;
  logic [SWW-1:0] swpre_next;
  logic [5:0]     sw_sec_next;
  logic [5:0]     sw_min_next;

  // Next stopwatch value: clear has priority, then run with saturation at 59:59.
  always_comb begin
    swpre_next  = swpre;
    sw_sec_next = sw_seconds;
    sw_min_next = sw_minutes;
    if (reset_stopwatch) begin
      swpre_next  = '0;
      sw_sec_next = '0;
      sw_min_next = '0;
    end else if (run_stopwatch) begin
      if (swpre == SW_LAST) begin
        swpre_next = '0;
        if (!(sw_minutes == 6'd59 && sw_seconds == 6'd59)) begin
          sw_sec_next = wrap_up60(sw_seconds);
          if (sw_seconds == 6'd59) sw_min_next = sw_minutes + 6'd1;
        end
      end else begin
        swpre_next = swpre + SWW'(1);
      end
    end
  end

  // Stopwatch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      swpre      <= '0;
      sw_seconds <= '0;
      sw_minutes <= '0;
    end else begin
      swpre      <= swpre_next;
      sw_seconds <= sw_sec_next;
      sw_minutes <= sw_min_next;
    end
  end

endmodule

// File: tb/tb_watch_timekeeper.sv
// tb_watch_timekeeper: directed bench for watch_timekeeper with fast prescalers.
// Expected values are queued as stimulus is applied and popped when compared.
module tb_watch_timekeeper;

  localparam int TPS = 4;
  localparam int SWT = 2;

`ifdef TWELVE_HOUR_EN
  localparam logic [31:0] H_RST = 32'd12;
`else
  localparam logic [31:0] H_RST = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       run_time;
  logic       inc_m;
  logic       dec_m;
  logic       inc_h;
  logic       dec_h;
  logic       run_stopwatch;
  logic       reset_stopwatch;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [5:0] sw_minutes;
  logic [5:0] sw_seconds;
  logic       sec_tick;
  logic       pm;

  watch_timekeeper #(
    .TICKS_PER_SEC   (TPS),
    .SW_TICKS_PER_SEC(SWT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run_time       (run_time),
    .inc_m          (inc_m),
    .dec_m          (dec_m),
    .inc_h          (inc_h),
    .dec_h          (dec_h),
    .run_stopwatch  (run_stopwatch),
    .reset_stopwatch(reset_stopwatch),
    .hours          (hours),
    .minutes        (minutes),
    .seconds        (seconds),
    .sw_minutes     (sw_minutes),
    .sw_seconds     (sw_seconds),
    .sec_tick       (sec_tick),
    .pm             (pm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   tick_cnt = 0;
  int   wide_cnt = 0;
  logic prev_tick = 1'b0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val && tag == e.tag) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d (queued as %s)", tag, obs, e.val, e.tag);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge and tracking sec_tick pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sec_tick) begin
        tick_cnt++;
        if (prev_tick) wide_cnt++;
      end
      prev_tick = sec_tick;
    end
  endtask

  // One-cycle adjust pulse followed by one idle cycle.
  task automatic adjust(input logic im, input logic dm, input logic ih, input logic dh);
    inc_m = im; dec_m = dm; inc_h = ih; dec_h = dh;
    step(1);
    inc_m = 1'b0; dec_m = 1'b0; inc_h = 1'b0; dec_h = 1'b0;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run_time = 1'b0;
    inc_m = 1'b0; dec_m = 1'b0; inc_h = 1'b0; dec_h = 1'b0;
    run_stopwatch = 1'b0; reset_stopwatch = 1'b0;

    // Reset state
    expect_v("rst_hours", H_RST);
    expect_v("rst_minutes", 0);
    expect_v("rst_seconds", 0);
    expect_v("rst_sw_minutes", 0);
    expect_v("rst_sw_seconds", 0);
    expect_v("rst_sec_tick", 0);
    expect_v("rst_pm", 0);
    step(2);
    check("rst_hours", hours);
    check("rst_minutes", minutes);
    check("rst_seconds", seconds);
    check("rst_sw_minutes", sw_minutes);
    check("rst_sw_seconds", sw_seconds);
    check("rst_sec_tick", sec_tick);
    check("rst_pm", pm);
    reset = 1'b0;

    // Prescaler: 16 running cycles give 4 seconds and 4 single-cycle ticks
    run_time = 1'b1; tick_cnt = 0; wide_cnt = 0;
    expect_v("run16_seconds", 4);
    expect_v("run16_ticks", 4);
    expect_v("run16_wide", 0);
    step(16);
    check("run16_seconds", seconds);
    check("run16_ticks", tick_cnt);
    check("run16_wide", wide_cnt);

    // Set mode holds seconds at 0 and stops ticks
    run_time = 1'b0;
    expect_v("setmode_seconds", 0);
    expect_v("setmode_tick", 0);
    step(1);
    check("setmode_seconds", seconds);
    check("setmode_tick", sec_tick);

    // Held inc_m gives exactly one step
    inc_m = 1'b1;
    expect_v("hold_inc_m_minutes", 1);
    expect_v("hold_inc_m_hours", H_RST);
    step(10);
    check("hold_inc_m_minutes", minutes);
    check("hold_inc_m_hours", hours);
    inc_m = 1'b0;
    step(1);

    // dec_m wraps 0 -> 59 without borrowing from hours
    adjust(1'b0, 1'b1, 1'b0, 1'b0);
    expect_v("dec_m_wrap_minutes", 59);
    expect_v("dec_m_wrap_hours", H_RST);
    adjust(1'b0, 1'b1, 1'b0, 1'b0);
    check("dec_m_wrap_minutes", minutes);
    check("dec_m_wrap_hours", hours);

    // inc_m and dec_m together: no change
    expect_v("inc_dec_m_minutes", 59);
    adjust(1'b1, 1'b1, 1'b0, 1'b0);
    check("inc_dec_m_minutes", minutes);

    // Minute and hour adjusts in the same cycle, no carry from minute wrap
    expect_v("both_up_minutes", 0);
    expect_v("both_up_hours", 1);
    adjust(1'b1, 1'b0, 1'b1, 1'b0);
    check("both_up_minutes", minutes);
    check("both_up_hours", hours);
    expect_v("both_dn_minutes", 59);
    expect_v("both_dn_hours", H_RST);
    expect_v("both_dn_pm", 0);
    adjust(1'b0, 1'b1, 1'b0, 1'b1);
    check("both_dn_minutes", minutes);
    check("both_dn_hours", hours);
    check("both_dn_pm", pm);

`ifndef TWELVE_HOUR_EN
    // Hour wrap in both directions
    expect_v("dec_h_wrap", 23);
    adjust(1'b0, 1'b0, 1'b0, 1'b1);
    check("dec_h_wrap", hours);
    expect_v("inc_h_wrap", 0);
    adjust(1'b0, 1'b0, 1'b1, 1'b0);
    check("inc_h_wrap", hours);
    adjust(1'b0, 1'b0, 1'b0, 1'b1);
    expect_v("inc_dec_h_hours", 23);
    adjust(1'b0, 1'b0, 1'b1, 1'b1);
    check("inc_dec_h_hours", hours);

    // 23:59:00 running for 60 s: full rollover in one edge
    run_time = 1'b1; tick_cnt = 0; wide_cnt = 0;
    expect_v("pre_roll_seconds", 59);
    expect_v("pre_roll_minutes", 59);
    expect_v("pre_roll_hours", 23);
    expect_v("pre_roll_ticks", 59);
    step(239);
    check("pre_roll_seconds", seconds);
    check("pre_roll_minutes", minutes);
    check("pre_roll_hours", hours);
    check("pre_roll_ticks", tick_cnt);
    expect_v("roll_seconds", 0);
    expect_v("roll_minutes", 0);
    expect_v("roll_hours", 0);
    expect_v("roll_tick", 1);
    expect_v("roll_ticks", 60);
    expect_v("roll_wide", 0);
    step(1);
    check("roll_seconds", seconds);
    check("roll_minutes", minutes);
    check("roll_hours", hours);
    check("roll_tick", sec_tick);
    check("roll_ticks", tick_cnt);
    check("roll_wide", wide_cnt);

    // Adjust while running is discarded; seconds keep running
    adjust(1'b0, 1'b0, 1'b1, 1'b0);
    expect_v("run_inc_h_hours", 0);
    expect_v("run_inc_h_seconds", 1);
    step(2);
    check("run_inc_h_hours", hours);
    check("run_inc_h_seconds", seconds);

    // inc_h held across the run -> set transition produces no step
    inc_h = 1'b1;
    step(1);
    run_time = 1'b0;
    expect_v("held_inc_h_hours", 0);
    expect_v("held_inc_h_seconds", 0);
    step(3);
    check("held_inc_h_hours", hours);
    check("held_inc_h_seconds", seconds);
    inc_h = 1'b0;
    step(1);
`else
    // 12-hour sequence with PM toggling at the 11/12 boundary
    for (int i = 0; i < 11; i++) adjust(1'b0, 1'b0, 1'b1, 1'b0);
    expect_v("h12_11_hours", 11);
    expect_v("h12_11_pm", 0);
    check("h12_11_hours", hours);
    check("h12_11_pm", pm);
    expect_v("h12_12_hours", 12);
    expect_v("h12_12_pm", 1);
    adjust(1'b0, 1'b0, 1'b1, 1'b0);
    check("h12_12_hours", hours);
    check("h12_12_pm", pm);
    expect_v("h12_1_hours", 1);
    expect_v("h12_1_pm", 1);
    adjust(1'b0, 1'b0, 1'b1, 1'b0);
    check("h12_1_hours", hours);
    check("h12_1_pm", pm);
    expect_v("h12_dec12_hours", 12);
    expect_v("h12_dec12_pm", 1);
    adjust(1'b0, 1'b0, 1'b0, 1'b1);
    check("h12_dec12_hours", hours);
    check("h12_dec12_pm", pm);
    expect_v("h12_dec11_hours", 11);
    expect_v("h12_dec11_pm", 0);
    adjust(1'b0, 1'b0, 1'b0, 1'b1);
    check("h12_dec11_hours", hours);
    check("h12_dec11_pm", pm);
`endif

    // Stopwatch: run, pause, clear
    run_stopwatch = 1'b1;
    expect_v("sw_run6_seconds", 3);
    expect_v("sw_run6_minutes", 0);
    step(6);
    check("sw_run6_seconds", sw_seconds);
    check("sw_run6_minutes", sw_minutes);
    run_stopwatch = 1'b0;
    expect_v("sw_pause_seconds", 3);
    step(10);
    check("sw_pause_seconds", sw_seconds);
    run_stopwatch = 1'b1; reset_stopwatch = 1'b1;
    expect_v("sw_clear_seconds", 0);
    expect_v("sw_clear_minutes", 0);
    step(1);
    check("sw_clear_seconds", sw_seconds);
    check("sw_clear_minutes", sw_minutes);
    reset_stopwatch = 1'b0;

    // Minute carry, then saturation at 59:59
    expect_v("sw_carry_minutes", 1);
    expect_v("sw_carry_seconds", 0);
    step(120);
    check("sw_carry_minutes", sw_minutes);
    check("sw_carry_seconds", sw_seconds);
    expect_v("sw_full_minutes", 59);
    expect_v("sw_full_seconds", 59);
    step(7078);
    check("sw_full_minutes", sw_minutes);
    check("sw_full_seconds", sw_seconds);
    expect_v("sw_sat_minutes", 59);
    expect_v("sw_sat_seconds", 59);
    step(20);
    check("sw_sat_minutes", sw_minutes);
    check("sw_sat_seconds", sw_seconds);

    // Reset mid-operation with inc_m held: clears, then one step after release
    inc_m = 1'b1; reset = 1'b1;
    expect_v("midrst_hours", H_RST);
    expect_v("midrst_minutes", 0);
    expect_v("midrst_sw_minutes", 0);
    expect_v("midrst_sw_seconds", 0);
    step(1);
    check("midrst_hours", hours);
    check("midrst_minutes", minutes);
    check("midrst_sw_minutes", sw_minutes);
    check("midrst_sw_seconds", sw_seconds);
    reset = 1'b0; run_stopwatch = 1'b0;
    expect_v("post_rst_minutes", 1);
    step(1);
    check("post_rst_minutes", minutes);
    expect_v("post_rst_held_minutes", 1);
    step(3);
    check("post_rst_held_minutes", minutes);
    inc_m = 1'b0;
    step(1);

    // Every queued expectation has been consumed
    total++;
    assert (sb.size() === 0) else begin
      bad++;
      $error("FAIL sb_drain: observed %0d leftover expectations expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
